// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - shared sprite/tile ROM port arbiter with tag-matched colour return
module sprite_rom_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 12,
  parameter int ROM_LAT = 2
) (
  input  logic                    clk,
  input  logic                    hard_reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic                    pri_mode,
  input  logic                    hold,
  output logic [N_REQ-1:0]        gnt,
  output logic                    rom_en,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic [N_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    busy
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic [N_REQ-1:0] elig;
  logic             inflight;

  // One-hot tag per ROM latency stage; stage k holds the grant issued k+1 cycles earlier.
  logic [N_REQ-1:0] tag_pipe [ROM_LAT];

  // The requester granted this cycle sits out the next arbitration.
  assign elig = req & ~gnt;

  // Winner select: lowest index in fixed mode, first set bit after ptr in round-robin mode.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    if (pri_mode) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (elig[i]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(i);
        end
      end
    end else begin
      // Scan from farthest to nearest so the nearest candidate after ptr is the last one kept.
      for (int k = N_REQ; k >= 1; k--) begin
        if (elig[IDX_W'((int'(ptr) + k) % N_REQ)]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'((int'(ptr) + k) % N_REQ);
        end
      end
    end
  end

  // Grant register, ROM strobe/address and round-robin pointer.
  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset) begin
      gnt      <= '0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
      ptr      <= IDX_W'(N_REQ - 1);
    end else if (!hold && win_found) begin
      gnt      <= N_REQ'(1) << win_idx;
      rom_en   <= 1'b1;
      rom_addr <= req_addr[win_idx*ADDR_W +: ADDR_W];
      if (!pri_mode) begin
        ptr <= win_idx;
      end
    end else begin
      gnt    <= '0;
      rom_en <= 1'b0;
    end
  end

  // Tag pipeline matched to ROM latency; the last stage steers the returned word.
  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset) begin
      for (int k = 0; k < ROM_LAT; k++) begin
        tag_pipe[k] <= '0;
      end
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      tag_pipe[0] <= gnt;
      for (int k = 1; k < ROM_LAT; k++) begin
        tag_pipe[k] <= tag_pipe[k-1];
      end
      rd_valid <= tag_pipe[ROM_LAT-1];
      if (|tag_pipe[ROM_LAT-1]) begin
        rd_data <= rom_data;
      end
    end
  end

  // Any tag still travelling towards rd_valid.
  always_comb begin
    inflight = 1'b0;
    for (int k = 0; k < ROM_LAT; k++) begin
      inflight = inflight | (|tag_pipe[k]);
    end
  end

  // Busy covers the grant cycle, the ROM wait and the return-strobe cycle.
  assign busy = inflight | (|gnt) | (|rd_valid);

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - scoreboard bench for sprite_rom_arbiter at ROM_LAT 2 and 4
module tb_sprite_rom_arbiter;

  typedef struct {
    int          cyc;
    logic [3:0]  vec;
    logic [13:0] addr;
    logic [11:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        hard_reset;
  logic [3:0]  req;
  logic [55:0] req_addr;
  logic        pri_mode;
  logic        hold;
  logic [13:0] ra [4];

  logic [3:0]  gnt2, rd_valid2, gnt4, rd_valid4;
  logic        rom_en2, busy2, rom_en4, busy4;
  logic [13:0] rom_addr2, rom_addr4;
  logic [11:0] rom_data2, rd_data2, rom_data4, rd_data4;

  logic [13:0] ap2 [2];
  logic [13:0] ap4 [4];

  exp_t gq2 [$];
  exp_t gq4 [$];
  exp_t rq2 [$];
  exp_t rq4 [$];
  exp_t m2, m4;
  logic [11:0] last2, last4;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int c0;

  int rr_seq [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
  int fx_seq [6]  = '{0, 1, 0, 1, 0, 1};
  int hd_seq [4]  = '{1, 0, 1, 0};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign req_addr = {ra[3], ra[2], ra[1], ra[0]};

  sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(14), .DATA_W(12), .ROM_LAT(2)) u_dut2 (
    .clk(clk), .hard_reset(hard_reset), .req(req), .req_addr(req_addr),
    .pri_mode(pri_mode), .hold(hold), .gnt(gnt2), .rom_en(rom_en2),
    .rom_addr(rom_addr2), .rom_data(rom_data2), .rd_valid(rd_valid2),
    .rd_data(rd_data2), .busy(busy2)
  );

  sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(14), .DATA_W(12), .ROM_LAT(4)) u_dut4 (
    .clk(clk), .hard_reset(hard_reset), .req(req), .req_addr(req_addr),
    .pri_mode(pri_mode), .hold(hold), .gnt(gnt4), .rom_en(rom_en4),
    .rom_addr(rom_addr4), .rom_data(rom_data4), .rd_valid(rd_valid4),
    .rd_data(rd_data4), .busy(busy4)
  );

  function automatic logic [11:0] rom_fn(input logic [13:0] a);
    if (a == 14'h0123) return 12'hF80;
    return a[11:0] ^ 12'h5A3;
  endfunction

  // Synchronous ROM models: address sampled each edge, data after ROM_LAT edges.
  always @(posedge clk) begin
    ap2[0] <= rom_addr2;
    ap2[1] <= ap2[0];
    ap4[0] <= rom_addr4;
    ap4[1] <= ap4[0];
    ap4[2] <= ap4[1];
    ap4[3] <= ap4[2];
  end
  assign rom_data2 = rom_fn(ap2[1]);
  assign rom_data4 = rom_fn(ap4[3]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Grant expected in cycle 'at'; data returns ROM_LAT+1 cycles after the grant.
  task automatic exp_grant(input int at, input int idx);
    exp_t e;
    e.cyc  = at;
    e.vec  = 4'b0001 << idx;
    e.addr = ra[idx];
    e.data = rom_fn(ra[idx]);
    gq2.push_back(e);
    gq4.push_back(e);
    e.cyc = at + 3;
    rq2.push_back(e);
    e.cyc = at + 5;
    rq4.push_back(e);
  endtask

  // Monitor: pops expectations whenever a DUT presents a grant or a return strobe.
  always @(negedge clk) begin
    if (hard_reset) begin
      last2 = '0;
      last4 = '0;
    end else begin
      if (rom_en2 || gnt2 != 0) begin
        checks++;
        if (gq2.size() == 0) begin
          errors++;
          $display("FAIL gnt_l2: unexpected gnt=%b en=%b at cycle %0d", gnt2, rom_en2, cyc);
        end else begin
          m2 = gq2.pop_front();
          if (m2.cyc != cyc || gnt2 !== m2.vec || rom_addr2 !== m2.addr || rom_en2 !== 1'b1) begin
            errors++;
            $display("FAIL gnt_l2: got cyc=%0d gnt=%b addr=%h en=%b expected cyc=%0d gnt=%b addr=%h en=1",
                     cyc, gnt2, rom_addr2, rom_en2, m2.cyc, m2.vec, m2.addr);
          end
        end
      end
      if (rom_en4 || gnt4 != 0) begin
        checks++;
        if (gq4.size() == 0) begin
          errors++;
          $display("FAIL gnt_l4: unexpected gnt=%b en=%b at cycle %0d", gnt4, rom_en4, cyc);
        end else begin
          m4 = gq4.pop_front();
          if (m4.cyc != cyc || gnt4 !== m4.vec || rom_addr4 !== m4.addr || rom_en4 !== 1'b1) begin
            errors++;
            $display("FAIL gnt_l4: got cyc=%0d gnt=%b addr=%h en=%b expected cyc=%0d gnt=%b addr=%h en=1",
                     cyc, gnt4, rom_addr4, rom_en4, m4.cyc, m4.vec, m4.addr);
          end
        end
      end
      if (rd_valid2 != 0) begin
        checks++;
        if (rq2.size() == 0) begin
          errors++;
          $display("FAIL rd_l2: unexpected rd_valid=%b at cycle %0d", rd_valid2, cyc);
        end else begin
          m2 = rq2.pop_front();
          last2 = m2.data;
          if (m2.cyc != cyc || rd_valid2 !== m2.vec || rd_data2 !== m2.data) begin
            errors++;
            $display("FAIL rd_l2: got cyc=%0d vld=%b data=%h expected cyc=%0d vld=%b data=%h",
                     cyc, rd_valid2, rd_data2, m2.cyc, m2.vec, m2.data);
          end
        end
      end else begin
        chk("rd_hold_l2", 32'(rd_data2), 32'(last2));
      end
      if (rd_valid4 != 0) begin
        checks++;
        if (rq4.size() == 0) begin
          errors++;
          $display("FAIL rd_l4: unexpected rd_valid=%b at cycle %0d", rd_valid4, cyc);
        end else begin
          m4 = rq4.pop_front();
          last4 = m4.data;
          if (m4.cyc != cyc || rd_valid4 !== m4.vec || rd_data4 !== m4.data) begin
            errors++;
            $display("FAIL rd_l4: got cyc=%0d vld=%b data=%h expected cyc=%0d vld=%b data=%h",
                     cyc, rd_valid4, rd_data4, m4.cyc, m4.vec, m4.data);
          end
        end
      end else begin
        chk("rd_hold_l4", 32'(rd_data4), 32'(last4));
      end
    end
  end

  initial begin
    ra[0] = 14'h1000;
    ra[1] = 14'h2A55;
    ra[2] = 14'h0123;
    ra[3] = 14'h3FFF;
    hard_reset = 1'b1;
    req = 4'b0000;
    pri_mode = 1'b0;
    hold = 1'b0;
    repeat (2) tick();

    // Reset state
    chk("rst_ctl_l2", {28'b0, rom_en2, busy2, |gnt2, |rd_valid2}, 32'h0);
    chk("rst_addr_l2", 32'(rom_addr2), 32'h0);
    chk("rst_data_l2", 32'(rd_data2), 32'h0);
    chk("rst_ctl_l4", {28'b0, rom_en4, busy4, |gnt4, |rd_valid4}, 32'h0);
    hard_reset = 1'b0;
    tick();

    // Round-robin with all four requesting: 0,1,2,3,...
    c0 = cyc;
    req = 4'b1111;
    for (int k = 0; k < 12; k++) exp_grant(c0 + 1 + k, rr_seq[k]);
    repeat (12) tick();
    req = 4'b0000;
    repeat (8) tick();

    // Single request from requester 2, dropped once granted
    c0 = cyc;
    req = 4'b0100;
    exp_grant(c0 + 1, 2);
    tick();
    req = 4'b0000;
    repeat (8) tick();

    // Reset one cycle after a grant: no return, pointer back to N_REQ-1
    req = 4'b0010;
    tick();
    req = 4'b0000;
    chk("mid_gnt", 32'(gnt2), 32'h2);
    chk("mid_addr", 32'(rom_addr2), 32'(ra[1]));
    hard_reset = 1'b1;
    #1;
    chk("mid_rst_l2", {gnt2, rd_valid2, 1'b0, rom_en2, busy2, 1'b0, rd_data2, 1'b0, rom_addr2[12:0]}, 32'h0);
    chk("mid_rst_l4", {gnt4, rd_valid4, 1'b0, rom_en4, busy4, 1'b0, rd_data4, 1'b0, rom_addr4[12:0]}, 32'h0);
    tick();
    hard_reset = 1'b0;
    tick();
    c0 = cyc;
    req = 4'b1111;
    exp_grant(c0 + 1, 0);
    tick();
    req = 4'b0000;
    repeat (8) tick();

    // Fixed priority: 0 and 1 alternate, 3 starved until they drop
    pri_mode = 1'b1;
    c0 = cyc;
    req = 4'b1011;
    for (int k = 0; k < 6; k++) exp_grant(c0 + 1 + k, fx_seq[k]);
    repeat (6) tick();
    req = 4'b1000;
    exp_grant(cyc + 1, 3);
    tick();
    req = 4'b0000;
    pri_mode = 1'b0;
    repeat (8) tick();

    // Hold: no grants for 5 cycles, in-flight reads drain, resume from saved pointer
    c0 = cyc;
    req = 4'b0011;
    for (int k = 0; k < 4; k++) exp_grant(c0 + 1 + k, hd_seq[k]);
    repeat (4) tick();
    hold = 1'b1;
    for (int h = 0; h < 5; h++) begin
      tick();
      chk("hold_gnt", {27'b0, rom_en2, gnt2}, 32'h0);
      if (cyc == c0 + 7) chk("hold_busy_last_l2", 32'(busy2), 32'h1);
      if (cyc == c0 + 8) chk("hold_busy_fall_l2", 32'(busy2), 32'h0);
      if (cyc == c0 + 9) chk("hold_busy_l4", 32'(busy4), 32'h1);
    end
    hold = 1'b0;
    exp_grant(c0 + 10, 1);
    exp_grant(c0 + 11, 0);
    repeat (2) tick();
    req = 4'b0000;
    repeat (10) tick();

    chk("drain_gq2", 32'(gq2.size()), 32'h0);
    chk("drain_gq4", 32'(gq4.size()), 32'h0);
    chk("drain_rq2", 32'(rq2.size()), 32'h0);
    chk("drain_rq4", 32'(rq4.size()), 32'h0);
    chk("idle_busy", {30'b0, busy2, busy4}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one synchronous sprite/tile colour ROM port among N_REQ pixel-fetch requesters (yoshi, enemy, platform, background units) inside display_top.
- Performs round-robin or fixed-priority arbitration, issues one ROM read per cycle, and returns the 12-bit colour word to the granted requester through a tag pipeline matched to the ROM latency.
- Runs on the pixel-domain clock, ahead of the rgb mux.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 14, ROM address width
- DATA_W, 12, ROM data width (RGB444)
- ROM_LAT, 2, cycles from rom_en/rom_addr edge to valid rom_data (1..4)

Ports:
- clk  in  1  single clock for all logic
- hard_reset  in  1  asynchronous, active-high reset
- req  in  N_REQ  level request per requester
- req_addr  in  N_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
- pri_mode  in  1  0=round-robin, 1=fixed priority (lowest index wins)
- hold  in  1  1=issue no new grants; in-flight reads complete
- gnt  out  N_REQ  registered one-hot grant
- rom_en  out  1  ROM read strobe
- rom_addr  out  ADDR_W  ROM address
- rom_data  in  DATA_W  ROM read data
- rd_valid  out  N_REQ  one-hot return strobe
- rd_data  out  DATA_W  returned colour word
- busy  out  1  1 while any read is in flight or gnt!=0

Behaviour:
- Reset (async, active-high): gnt=0, rom_en=0, rom_addr=0, rd_valid=0, rd_data=0, busy=0, tag pipeline cleared, rr pointer=N_REQ-1 (so requester 0 wins first).
- Cycle t, eligible set E = req & ~gnt (a requester granted in cycle t is masked; no back-to-back grant to the same index).
- If hold=1 or E=0: next gnt=0, rom_en=0, rom_addr holds its value.
- Round-robin (pri_mode=0): winner = first set bit of E searching ptr+1, ptr+2, ... modulo N_REQ; on grant, ptr<=winner.
- Fixed (pri_mode=1): winner = lowest set index of E; ptr unchanged.
- pri_mode and hold are sampled every cycle, so a change takes effect on the next arbitration.
- Edge t+1: gnt[winner]=1, rom_en=1, rom_addr=req_addr[winner].
- Tag (valid + index) shifts ROM_LAT stages.
- Edge t+1+ROM_LAT: rom_data is valid.
- Edge t+2+ROM_LAT: rd_valid[winner]=1 for exactly 1 cycle, rd_data=registered rom_data.
- Total req-to-data latency is ROM_LAT+2 cycles.
- One grant per cycle at most; throughput is 1 read/cycle with at least 2 active requesters.
- rd_data holds its last value when rd_valid=0.
- A requester that wants a single read must drop req by the edge after it sees gnt; if req stays high, it is re-eligible one cycle later.
- hold does not flush the pipeline; busy stays 1 until the last rd_valid has been issued.
- Reset mid-operation: in-flight tags are discarded and no rd_valid is produced for them.
- Requests with an address but req=0 are ignored.

Test Plan:
1. Reset mid-read: assert hard_reset 1 cycle after gnt -> all outputs 0 immediately; no rd_valid afterwards; after release, req[0] is granted first.
2. Single request: req=4'b0100, req_addr[2]=14'h0123, ROM returns 12'hF80 -> gnt=4'b0100 at t+1, rom_addr=0x0123, rd_valid=4'b0100 with rd_data=12'hF80 at t+4 (ROM_LAT=2); req dropped after gnt gives exactly one read.
3. Round-robin fairness: req=4'b1111 held 12 cycles -> grant order 0,1,2,3,0,1,... with no index granted on consecutive cycles; rd_valid sequence mirrors the grants 3 cycles later.
4. Fixed priority: pri_mode=1, req=4'b1011 held -> grants alternate 0,1,0,1 (bit 0 masked only in its granted cycle); requester 3 is never granted until req[0]=req[1]=0.
5. Hold: req=4'b0011 running, hold=1 for 5 cycles -> gnt=0 and rom_en=0 during hold; the two in-flight reads still return with rd_valid; busy falls after the last one; grants resume from the saved ptr after hold=0.
6. ROM_LAT=4 build: single request -> rd_valid at t+6 with correct index and data; back-to-back grants return in order.
